// File: rtl/wb32_fta128_bridge_pkg.sv
// FTA 128-bit command bus types plus the Wishbone-to-FTA bridge state and defaults.
package wb32_fta128_bridge_pkg;

    typedef struct packed {
        logic         cyc;
        logic         stb;
        logic         we;
        logic [15:0]  sel;
        logic [31:0]  padr;
        logic [127:0] data1;
        logic [3:0]   cid;
        logic [7:0]   tid;
    } fta_cmd_request128_t;

    typedef struct packed {
        logic         ack;
        logic         err;
        logic         rty;
        logic         stall;
        logic [127:0] dat;
        logic [3:0]   cid;
        logic [7:0]   tid;
    } fta_cmd_response128_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RESP,
        ST_DONE
    } wb2fta_state_t;

    localparam logic [3:0] WB2FTA_CID     = 4'd3;
    localparam int         WB2FTA_TIMEOUT = 1023;
    localparam int         WB2FTA_MAX_RTY = 3;

endpackage

// File: rtl/wb32_fta128_bridge_if.sv
// Wishbone-classic 32-bit target side plus FTA 128-bit request/response of the bridge.
interface wb32_fta128_bridge_if;
    import wb32_fta128_bridge_pkg::*;

    logic                 s_cyc_i;
    logic                 s_stb_i;
    logic                 s_we_i;
    logic [3:0]           s_sel_i;
    logic [31:0]          s_adr_i;
    logic [31:0]          s_dat_i;
    logic [31:0]          s_dat_o;
    logic                 s_ack_o;
    logic                 s_err_o;
    fta_cmd_request128_t  m_req;
    fta_cmd_response128_t m_resp;

    // slave: the bridge itself; master: the Wishbone initiator plus FTA fabric around it
    modport slave (
        input  s_cyc_i, s_stb_i, s_we_i, s_sel_i, s_adr_i, s_dat_i, m_resp,
        output s_dat_o, s_ack_o, s_err_o, m_req
    );

    modport master (
        output s_cyc_i, s_stb_i, s_we_i, s_sel_i, s_adr_i, s_dat_i, m_resp,
        input  s_dat_o, s_ack_o, s_err_o, m_req
    );

endinterface

// File: rtl/wb32_fta128_lanes.sv
// Purpose: steer a 32-bit word/byte-select onto a 128-bit beat and extract a read lane.
// Latency: combinational. Backpressure: none, pure datapath.
module wb32_fta128_lanes (
    input  logic [1:0]   lane,
    input  logic [3:0]   sel,
    input  logic [31:0]  wdat,
    input  logic [127:0] rdat,
    output logic [15:0]  sel_wide,
    output logic [127:0] wdat_wide,
    output logic [31:0]  rdat_lane
);
    logic [127:0] rdat_shift;

    assign sel_wide   = {12'd0, sel} << {lane, 2'b00};
    assign wdat_wide  = {4{wdat}};
    assign rdat_shift = rdat >> {lane, 5'd0};
    assign rdat_lane  = rdat_shift[31:0];

endmodule

// File: rtl/wb32_fta128_bridge.sv
// Purpose: Wishbone 32-bit target to FTA 128-bit initiator, one tagged transaction outstanding.
// Latency: stb sampled cycle 0 -> m_req cycle 1; matched response cycle N -> ack/err cycle N+1.
// Backpressure: m_req held while m_resp.stall; Wishbone ack/err held until stb drops.
module wb32_fta128_bridge
    import wb32_fta128_bridge_pkg::*;
#(
    parameter logic [3:0] CID     = WB2FTA_CID,
    parameter int         TIMEOUT = WB2FTA_TIMEOUT,
    parameter int         MAX_RTY = WB2FTA_MAX_RTY
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    wb32_fta128_bridge_if.slave bus
);
    localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT);
    localparam logic [7:0] RTY_LIMIT = 8'(MAX_RTY);

    wb2fta_state_t       state;
    fta_cmd_request128_t req_q;
    logic [7:0]          tid_q;
    logic [7:0]          rty_cnt;
    logic [9:0]          tmo_cnt;
    logic                we_q;
    logic [1:0]          lane_q;
    logic                ack_q;
    logic                err_q;
    logic [31:0]         dat_q;

    logic [1:0]          lane;
    logic [15:0]         sel_wide;
    logic [127:0]        wdat_wide;
    logic [31:0]         rdat_lane;
    logic                match;

    // Request steering uses the live address; read extraction uses the latched lane.
    assign lane = (state == ST_IDLE) ? bus.s_adr_i[3:2] : lane_q;

    wb32_fta128_lanes u_lanes (
        .lane      (lane),
        .sel       (bus.s_sel_i),
        .wdat      (bus.s_dat_i),
        .rdat      (bus.m_resp.dat),
        .sel_wide  (sel_wide),
        .wdat_wide (wdat_wide),
        .rdat_lane (rdat_lane)
    );

    assign match = (bus.m_resp.ack | bus.m_resp.err | bus.m_resp.rty)
                && (bus.m_resp.cid == CID) && (bus.m_resp.tid == tid_q);

    assign bus.m_req   = req_q;
    assign bus.s_ack_o = ack_q;
    assign bus.s_err_o = err_q;
    assign bus.s_dat_o = dat_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= ST_IDLE;
            req_q   <= '0;
            tid_q   <= 8'd0;
            rty_cnt <= 8'd0;
            tmo_cnt <= 10'd0;
            we_q    <= 1'b0;
            lane_q  <= 2'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= 32'd0;
        end else if ((state == ST_REQ || state == ST_WAIT_RESP) && !bus.s_cyc_i) begin
            // Abort beats any same-cycle response; bumping tid orphans the stale reply.
            req_q   <= '0;
            tid_q   <= tid_q + 8'd1;
            rty_cnt <= 8'd0;
            state   <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.s_cyc_i && bus.s_stb_i) begin
                        we_q        <= bus.s_we_i;
                        lane_q      <= bus.s_adr_i[3:2];
                        req_q.cyc   <= 1'b1;
                        req_q.stb   <= 1'b1;
                        req_q.we    <= bus.s_we_i;
                        req_q.sel   <= sel_wide;
                        req_q.padr  <= {bus.s_adr_i[31:4], 4'h0};
                        req_q.data1 <= wdat_wide;
                        req_q.cid   <= CID;
                        req_q.tid   <= tid_q;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (!bus.m_resp.stall) begin
                        req_q.cyc <= 1'b0;
                        req_q.stb <= 1'b0;
                        tmo_cnt   <= 10'd0;
                        state     <= ST_WAIT_RESP;
                    end
                end
                ST_WAIT_RESP: begin
                    if (match && bus.m_resp.ack) begin
                        ack_q <= 1'b1;
                        dat_q <= we_q ? 32'd0 : rdat_lane;
                        state <= ST_DONE;
                    end else if ((match && bus.m_resp.err) || tmo_cnt == TMO_LIMIT) begin
                        err_q <= 1'b1;
                        state <= ST_DONE;
                    end else if (match && bus.m_resp.rty) begin
                        if (rty_cnt < RTY_LIMIT) begin
                            // Other request fields are still intact, so re-raising cyc/stb reissues it.
                            rty_cnt   <= rty_cnt + 8'd1;
                            req_q.cyc <= 1'b1;
                            req_q.stb <= 1'b1;
                            state     <= ST_REQ;
                        end else begin
                            err_q <= 1'b1;
                            state <= ST_DONE;
                        end
                    end else if (tmo_cnt != TMO_LIMIT) begin
                        tmo_cnt <= tmo_cnt + 10'd1;
                    end
                end
                ST_DONE: begin
                    if (!bus.s_stb_i) begin
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                        dat_q   <= 32'd0;
                        tid_q   <= tid_q + 8'd1;
                        rty_cnt <= 8'd0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb32_fta128_bridge.sv
// Directed bench for wb32_fta128_bridge with a queue of expected Wishbone completions.
module tb_wb32_fta128_bridge;
    import wb32_fta128_bridge_pkg::*;

    typedef logic [199:0] cv_t;
    typedef struct {
        bit          is_err;
        logic [31:0] dat;
    } exp_t;

    localparam logic [127:0] D1 = 128'hFFFFEEEE_CCCCDDDD_DDDDCCCC_BBBBAAAA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb32_fta128_bridge_if bus();

    wb32_fta128_bridge dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    exp_t                sb[$];
    int                  total = 0;
    int                  bad = 0;
    int                  n;
    int                  issues;
    fta_cmd_request128_t snap;

    task automatic chk(input string tag, input cv_t obs, input cv_t expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic wb_start(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] dat);
        @(posedge clk); #1;
        bus.s_cyc_i = 1'b1; bus.s_stb_i = 1'b1; bus.s_we_i = we;
        bus.s_adr_i = adr;  bus.s_sel_i = sel;  bus.s_dat_i = dat;
    endtask

    task automatic push_exp(input bit is_err, input logic [31:0] dat);
        exp_t e;
        e.is_err = is_err;
        e.dat    = dat;
        sb.push_back(e);
    endtask

    // Request must appear exactly one cycle after stb is sampled.
    task automatic wait_req(input string tag);
        int k = 0;
        @(negedge clk);
        while (!bus.m_req.cyc && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_req_lat"}, cv_t'(k), cv_t'(1));
    endtask

    task automatic send_resp(input logic a, input logic e, input logic r, input logic [3:0] cid,
                             input logic [7:0] tid, input logic [127:0] d);
        @(posedge clk); #1;
        bus.m_resp.ack = a; bus.m_resp.err = e; bus.m_resp.rty = r;
        bus.m_resp.cid = cid; bus.m_resp.tid = tid; bus.m_resp.dat = d;
        @(posedge clk); #1;
        bus.m_resp.ack = 1'b0; bus.m_resp.err = 1'b0; bus.m_resp.rty = 1'b0;
    endtask

    // Waits for ack/err, checks it against the scoreboard, then ends the Wishbone cycle.
    task automatic wait_result(input string tag, input int lat_exp);
        int   k = 0;
        exp_t e;
        @(negedge clk);
        while (!(bus.s_ack_o || bus.s_err_o) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (lat_exp >= 0) chk({tag, "_done_lat"}, cv_t'(k), cv_t'(lat_exp));
        chk({tag, "_sb_nonempty"}, cv_t'(sb.size() > 0), cv_t'(1));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_ack"}, cv_t'(bus.s_ack_o), cv_t'(!e.is_err));
            chk({tag, "_err"}, cv_t'(bus.s_err_o), cv_t'(e.is_err));
            chk({tag, "_dat"}, cv_t'(bus.s_dat_o), cv_t'(e.is_err ? 32'd0 : e.dat));
        end
        @(negedge clk);
        chk({tag, "_hold"}, cv_t'(bus.s_ack_o | bus.s_err_o), cv_t'(1));
        @(posedge clk); #1;
        bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0; bus.s_we_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_clear"}, cv_t'({bus.s_ack_o, bus.s_err_o, bus.s_dat_o}), cv_t'(0));
    endtask

    initial begin
        bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0; bus.s_we_i = 1'b0;
        bus.s_sel_i = 4'd0; bus.s_adr_i = 32'd0; bus.s_dat_i = 32'd0;
        bus.m_resp  = '0;
        repeat (3) @(negedge clk);
        chk("rst_outs", cv_t'({bus.s_ack_o, bus.s_err_o, bus.s_dat_o}), cv_t'(0));
        chk("rst_mreq", cv_t'(bus.m_req), cv_t'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        // Read, lane 2
        push_exp(1'b0, 32'hCCCCDDDD);
        wb_start(1'b0, 32'h0000_1008, 4'hF, 32'd0);
        wait_req("rd");
        chk("rd_sel",  cv_t'(bus.m_req.sel),  cv_t'(16'h0F00));
        chk("rd_padr", cv_t'(bus.m_req.padr), cv_t'(32'h0000_1000));
        chk("rd_we",   cv_t'(bus.m_req.we),   cv_t'(0));
        chk("rd_cid",  cv_t'(bus.m_req.cid),  cv_t'(4'd3));
        chk("rd_tid",  cv_t'(bus.m_req.tid),  cv_t'(8'd0));
        send_resp(1'b1, 1'b0, 1'b0, 4'd3, 8'd0, D1);
        wait_result("rd", 0);

        // Write, lane 3
        push_exp(1'b0, 32'd0);
        wb_start(1'b1, 32'h0000_100C, 4'h3, 32'h0000_1234);
        wait_req("wr");
        chk("wr_sel",   cv_t'(bus.m_req.sel),   cv_t'(16'h3000));
        chk("wr_data1", cv_t'(bus.m_req.data1), cv_t'({4{32'h0000_1234}}));
        chk("wr_we",    cv_t'(bus.m_req.we),    cv_t'(1));
        chk("wr_tid",   cv_t'(bus.m_req.tid),   cv_t'(8'd1));
        send_resp(1'b1, 1'b0, 1'b0, 4'd3, 8'd1, D1);
        wait_result("wr", 0);

        // Wrong tid then wrong cid ignored, then matching response
        push_exp(1'b0, 32'hBBBBAAAA);
        wb_start(1'b0, 32'h0000_1000, 4'hF, 32'd0);
        wait_req("tag");
        send_resp(1'b1, 1'b0, 1'b0, 4'd3, 8'd3, D1);
        @(negedge clk);
        chk("tag_wrong_tid", cv_t'(bus.s_ack_o | bus.s_err_o), cv_t'(0));
        send_resp(1'b1, 1'b0, 1'b0, 4'd5, 8'd2, D1);
        @(negedge clk);
        chk("tag_wrong_cid", cv_t'(bus.s_ack_o | bus.s_err_o), cv_t'(0));
        send_resp(1'b1, 1'b0, 1'b0, 4'd3, 8'd2, D1);
        wait_result("tag", 0);

        // Two retries then ack: three issues with the same tid
        push_exp(1'b0, 32'hDDDDCCCC);
        wb_start(1'b0, 32'h0000_1004, 4'hF, 32'd0);
        wait_req("rty2");
        issues = 1;
        for (int i = 0; i < 2; i++) begin
            send_resp(1'b0, 1'b0, 1'b1, 4'd3, 8'd3, 128'd0);
            @(negedge clk);
            if (bus.m_req.cyc) issues++;
            chk("rty2_tid", cv_t'(bus.m_req.tid), cv_t'(8'd3));
        end
        chk("rty2_issues", cv_t'(issues), cv_t'(3));
        send_resp(1'b1, 1'b0, 1'b0, 4'd3, 8'd3, D1);
        wait_result("rty2", 0);

        // Four retries exhaust the budget
        push_exp(1'b1, 32'd0);
        wb_start(1'b0, 32'h0000_1000, 4'hF, 32'd0);
        wait_req("rty4");
        for (int i = 0; i < 3; i++) begin
            send_resp(1'b0, 1'b0, 1'b1, 4'd3, 8'd4, 128'd0);
            @(negedge clk);
            chk("rty4_reissue", cv_t'(bus.m_req.cyc), cv_t'(1));
        end
        send_resp(1'b0, 1'b0, 1'b1, 4'd3, 8'd4, 128'd0);
        wait_result("rty4", 0);

        // Timeout: tmo_cnt is 0 on the first WAIT_RESP cycle, err shows 1024 cycles later
        push_exp(1'b1, 32'd0);
        wb_start(1'b0, 32'h0000_1000, 4'hF, 32'd0);
        wait_req("tmo");
        @(negedge clk);
        chk("tmo_wait_entry", cv_t'(bus.m_req.cyc), cv_t'(0));
        n = 0;
        while (!bus.s_err_o && n < 1100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_cycles", cv_t'(n), cv_t'(1024));
        wait_result("tmo", 0);

        // Stall holds the request, then abort and late ack
        bus.m_resp.stall = 1'b1;
        wb_start(1'b0, 32'h0000_2000, 4'hF, 32'd0);
        wait_req("stall");
        snap = bus.m_req;
        chk("stall_tid", cv_t'(snap.tid), cv_t'(8'd6));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_hold", cv_t'(bus.m_req), cv_t'(snap));
        end
        @(posedge clk); #1 bus.m_resp.stall = 1'b0;
        @(negedge clk);
        chk("stall_last", cv_t'(bus.m_req.cyc), cv_t'(1));
        @(negedge clk);
        chk("stall_release", cv_t'(bus.m_req.cyc), cv_t'(0));
        @(posedge clk); #1 bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0;
        send_resp(1'b1, 1'b0, 1'b0, 4'd3, 8'd6, D1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_late", cv_t'({bus.s_ack_o, bus.s_err_o, bus.m_req.cyc}), cv_t'(0));
        end

        // Abort in the same cycle as a matching response
        wb_start(1'b0, 32'h0000_3000, 4'hF, 32'd0);
        wait_req("abort2");
        chk("abort2_tid", cv_t'(bus.m_req.tid), cv_t'(8'd7));
        @(posedge clk); #1;
        bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0;
        bus.m_resp.ack = 1'b1; bus.m_resp.cid = 4'd3; bus.m_resp.tid = 8'd7; bus.m_resp.dat = D1;
        @(posedge clk); #1 bus.m_resp.ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort2_none", cv_t'(bus.s_ack_o | bus.s_err_o), cv_t'(0));
        end

        // Normal read after aborts uses the advanced tid
        push_exp(1'b0, 32'hFFFFEEEE);
        wb_start(1'b0, 32'h0000_300C, 4'hF, 32'd0);
        wait_req("post");
        chk("post_tid", cv_t'(bus.m_req.tid), cv_t'(8'd8));
        send_resp(1'b1, 1'b0, 1'b0, 4'd3, 8'd8, D1);
        wait_result("post", 0);

        // Reset mid-transaction
        wb_start(1'b0, 32'h0000_1000, 4'hF, 32'd0);
        wait_req("mrst");
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_mreq", cv_t'(bus.m_req), cv_t'(0));
        bus.s_cyc_i = 1'b0; bus.s_stb_i = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        send_resp(1'b1, 1'b0, 1'b0, 4'd3, 8'd9, D1);
        @(negedge clk);
        chk("mrst_ignored", cv_t'(bus.s_ack_o | bus.s_err_o), cv_t'(0));
        push_exp(1'b0, 32'hCCCCDDDD);
        wb_start(1'b0, 32'h0000_1008, 4'hF, 32'd0);
        wait_req("mrst2");
        chk("mrst2_tid", cv_t'(bus.m_req.tid), cv_t'(8'd0));
        send_resp(1'b1, 1'b0, 1'b0, 4'd3, 8'd0, D1);
        wait_result("mrst2", 0);

        chk("sb_drained", cv_t'(sb.size()), cv_t'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
